// File: rtl/traffic_ctrl_n.sv
// N-direction traffic-light sequencer: GREEN -> YELLOW -> ALL-RED per direction,
// with optional request-actuated skip/extend and a run-enable that freezes timing.
module traffic_ctrl_n #(
    parameter int NUM_DIR  = 2,
    parameter int TW       = 16,
    parameter int ACTUATED = 1,
    parameter int IW       = 3
) (
    input  logic               ck,
    input  logic               rst,
    input  logic               en,
    input  logic [TW-1:0]      ld_green,
    input  logic [TW-1:0]      ld_yellow,
    input  logic [TW-1:0]      ld_allred,
    input  logic [NUM_DIR-1:0] req,
    output logic [NUM_DIR-1:0] g,
    output logic [NUM_DIR-1:0] y,
    output logic [NUM_DIR-1:0] r,
    output logic [IW-1:0]      active,
    output logic               phase_done
);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      active_q, active_d;
    logic [IW-1:0]      nxt_q, nxt_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               phaseDone_q, phaseDone_d;
    logic [NUM_DIR-1:0] g_q, g_d;
    logic [NUM_DIR-1:0] y_q, y_d;
    logic [NUM_DIR-1:0] r_q, r_d;
    logic [NUM_DIR-1:0] reqEff;
    logic [NUM_DIR-1:0] oneHot;
    logic [IW:0]        pick;

    function automatic logic [TW-1:0] clampDur(input logic [TW-1:0] d);
        return (d == '0) ? TW'(1) : d;
    endfunction

    // Returns {found, index}: nearest requesting direction after cur, wrapping at NUM_DIR.
    function automatic logic [IW:0] pickNext(input logic [IW-1:0] cur,
                                             input logic [NUM_DIR-1:0] rq);
        logic [IW:0]        res;
        logic [NUM_DIR-1:0] rqSh;
        int                 cand;
        res = '0;
        for (int k = NUM_DIR - 1; k >= 1; k--) begin
            cand = int'(cur) + k;
            if (cand >= NUM_DIR) begin
                cand = cand - NUM_DIR;
            end
            rqSh = rq >> cand;
            if (rqSh[0]) begin
                res = {1'b1, IW'(cand)};
            end
        end
        return res;
    endfunction

    // Fixed mode is the actuated scan with every direction requesting.
    assign reqEff = (ACTUATED != 0) ? req : '1;
    assign pick   = pickNext(active_q, reqEff);

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        nxt_d       = nxt_q;
        timer_d     = timer_q;
        phaseDone_d = 1'b0;
        if (en) begin
            if (timer_q <= TW'(1)) begin
                case (state_q)
                    ST_ALLRED: begin
                        state_d     = ST_GREEN;
                        active_d    = nxt_q;
                        timer_d     = clampDur(ld_green);
                        phaseDone_d = 1'b1;
                    end
                    ST_GREEN: begin
                        if (pick[IW]) begin
                            state_d     = ST_YELLOW;
                            nxt_d       = pick[IW-1:0];
                            timer_d     = clampDur(ld_yellow);
                            phaseDone_d = 1'b1;
                        end else begin
                            timer_d = clampDur(ld_green);
                        end
                    end
                    ST_YELLOW: begin
                        state_d     = ST_ALLRED;
                        timer_d     = clampDur(ld_allred);
                        phaseDone_d = 1'b1;
                    end
                    default: begin
                        state_d = ST_ALLRED;
                        timer_d = clampDur(ld_allred);
                    end
                endcase
            end else begin
                timer_d = timer_q - TW'(1);
            end
        end

        oneHot = NUM_DIR'(1) << active_d;
        g_d    = '0;
        y_d    = '0;
        r_d    = '1;
        case (state_d)
            ST_GREEN: begin
                g_d = oneHot;
                r_d = ~oneHot;
            end
            ST_YELLOW: begin
                y_d = oneHot;
                r_d = ~oneHot;
            end
            default: begin
                r_d = '1;
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q     <= ST_ALLRED;
            active_q    <= '0;
            nxt_q       <= '0;
            timer_q     <= clampDur(ld_allred);
            phaseDone_q <= 1'b0;
            g_q         <= '0;
            y_q         <= '0;
            r_q         <= '1;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            nxt_q       <= nxt_d;
            timer_q     <= timer_d;
            phaseDone_q <= phaseDone_d;
            g_q         <= g_d;
            y_q         <= y_d;
            r_q         <= r_d;
        end
    end

    assign g          = g_q;
    assign y          = y_q;
    assign r          = r_q;
    assign active     = active_q;
    assign phase_done = phaseDone_q;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Directed bench for traffic_ctrl_n: a 2-direction fixed-cycle instance (A)
// and a 4-direction actuated instance (B), checked against hand-derived lamp sequences.
module tb_traffic_ctrl_n;

    logic        ck;
    int          checks;
    int          errors;

    logic        rstA, enA;
    logic [15:0] ldGreenA, ldYellowA, ldAllredA;
    logic [1:0]  reqA;
    logic [1:0]  gA, yA, rA;
    logic [2:0]  actA;
    logic        pdA;

    logic        rstB, enB;
    logic [15:0] ldGreenB, ldYellowB, ldAllredB;
    logic [3:0]  reqB;
    logic [3:0]  gB, yB, rB;
    logic [2:0]  actB;
    logic        pdB;

    traffic_ctrl_n #(.NUM_DIR(2), .TW(16), .ACTUATED(0), .IW(3)) dutA (
        .ck(ck), .rst(rstA), .en(enA),
        .ld_green(ldGreenA), .ld_yellow(ldYellowA), .ld_allred(ldAllredA),
        .req(reqA), .g(gA), .y(yA), .r(rA), .active(actA), .phase_done(pdA)
    );

    traffic_ctrl_n #(.NUM_DIR(4), .TW(16), .ACTUATED(1), .IW(3)) dutB (
        .ck(ck), .rst(rstB), .en(enB),
        .ld_green(ldGreenB), .ld_yellow(ldYellowB), .ld_allred(ldAllredB),
        .req(reqB), .g(gB), .y(yB), .r(rB), .active(actB), .phase_done(pdB)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkA(input string tag, input logic [1:0] eg, input logic [1:0] ey,
                          input logic [1:0] er, input logic [2:0] eact, input logic epd);
        checkOutput(tag, 32'({gA, yA, rA, actA, pdA}), 32'({eg, ey, er, eact, epd}));
    endtask

    task automatic checkB(input string tag, input logic [3:0] eg, input logic [3:0] ey,
                          input logic [3:0] er, input logic [2:0] eact, input logic epd);
        checkOutput(tag, 32'({gB, yB, rB, actB, pdB}), 32'({eg, ey, er, eact, epd}));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rstA      = 1'b1;
        enA       = 1'b1;
        ldGreenA  = 16'd5;
        ldYellowA = 16'd2;
        ldAllredA = 16'd1;
        reqA      = 2'b00;
        rstB      = 1'b1;
        enB       = 1'b1;
        ldGreenB  = 16'd3;
        ldYellowB = 16'd2;
        ldAllredB = 16'd1;
        reqB      = 4'b0100;

        $display("[TB] instance A: 2 directions, fixed round-robin");
        applyStimulus(1);
        rstA = 1'b0;
        checkA("A_reset",       2'b00, 2'b00, 2'b11, 3'd0, 1'b0);
        applyStimulus(1);
        checkA("A_g0_entry",    2'b01, 2'b00, 2'b10, 3'd0, 1'b1);
        applyStimulus(1);
        checkA("A_g0_hold",     2'b01, 2'b00, 2'b10, 3'd0, 1'b0);
        applyStimulus(3);
        checkA("A_g0_last",     2'b01, 2'b00, 2'b10, 3'd0, 1'b0);
        applyStimulus(1);
        checkA("A_y0_entry",    2'b00, 2'b01, 2'b10, 3'd0, 1'b1);
        applyStimulus(1);
        checkA("A_y0_last",     2'b00, 2'b01, 2'b10, 3'd0, 1'b0);
        applyStimulus(1);
        checkA("A_allred",      2'b00, 2'b00, 2'b11, 3'd0, 1'b1);
        applyStimulus(1);
        checkA("A_g1_entry",    2'b10, 2'b00, 2'b01, 3'd1, 1'b1);
        applyStimulus(5);
        checkA("A_y1_entry",    2'b00, 2'b10, 2'b01, 3'd1, 1'b1);
        applyStimulus(3);
        checkA("A_g0_period16", 2'b01, 2'b00, 2'b10, 3'd0, 1'b1);

        applyStimulus(3);
        enA = 1'b0;
        applyStimulus(1);
        checkA("A_frozen_1",    2'b01, 2'b00, 2'b10, 3'd0, 1'b0);
        applyStimulus(3);
        checkA("A_frozen_4",    2'b01, 2'b00, 2'b10, 3'd0, 1'b0);
        enA = 1'b1;
        applyStimulus(1);
        checkA("A_resume_1",    2'b01, 2'b00, 2'b10, 3'd0, 1'b0);
        applyStimulus(1);
        checkA("A_resume_2",    2'b00, 2'b01, 2'b10, 3'd0, 1'b1);

        $display("[TB] instance A: zero yellow and mid-phase duration change");
        rstA      = 1'b1;
        ldYellowA = 16'd0;
        applyStimulus(1);
        rstA = 1'b0;
        checkA("A_reset2",      2'b00, 2'b00, 2'b11, 3'd0, 1'b0);
        applyStimulus(2);
        ldGreenA = 16'd9;
        applyStimulus(3);
        checkA("A_old_g_last",  2'b01, 2'b00, 2'b10, 3'd0, 1'b0);
        applyStimulus(1);
        checkA("A_y_zero",      2'b00, 2'b01, 2'b10, 3'd0, 1'b1);
        applyStimulus(1);
        checkA("A_y_one_cyc",   2'b00, 2'b00, 2'b11, 3'd0, 1'b1);
        applyStimulus(1);
        checkA("A_g9_entry",    2'b10, 2'b00, 2'b01, 3'd1, 1'b1);
        applyStimulus(8);
        checkA("A_g9_last",     2'b10, 2'b00, 2'b01, 3'd1, 1'b0);
        applyStimulus(1);
        checkA("A_g9_end",      2'b00, 2'b10, 2'b01, 3'd1, 1'b1);

        $display("[TB] instance B: 4 directions, actuated");
        applyStimulus(1);
        rstB = 1'b0;
        checkB("B_reset",       4'b0000, 4'b0000, 4'b1111, 3'd0, 1'b0);
        applyStimulus(1);
        checkB("B_g0_entry",    4'b0001, 4'b0000, 4'b1110, 3'd0, 1'b1);
        applyStimulus(3);
        checkB("B_y0_entry",    4'b0000, 4'b0001, 4'b1110, 3'd0, 1'b1);
        applyStimulus(2);
        checkB("B_allred",      4'b0000, 4'b0000, 4'b1111, 3'd0, 1'b1);
        applyStimulus(1);
        checkB("B_skip_to2",    4'b0100, 4'b0000, 4'b1011, 3'd2, 1'b1);
        reqB = 4'b0000;
        applyStimulus(1);
        reqB = 4'b0010;
        applyStimulus(1);
        reqB = 4'b0000;
        applyStimulus(1);
        checkB("B_extend_1",    4'b0100, 4'b0000, 4'b1011, 3'd2, 1'b0);
        applyStimulus(3);
        checkB("B_extend_2",    4'b0100, 4'b0000, 4'b1011, 3'd2, 1'b0);
        reqB = 4'b0010;
        applyStimulus(3);
        checkB("B_req_yellow",  4'b0000, 4'b0100, 4'b1011, 3'd2, 1'b1);
        applyStimulus(3);
        checkB("B_wrap_to1",    4'b0010, 4'b0000, 4'b1101, 3'd1, 1'b1);
        reqB = 4'b1000;
        applyStimulus(6);
        checkB("B_g3_entry",    4'b1000, 4'b0000, 4'b0111, 3'd3, 1'b1);
        reqB = 4'b0001;
        applyStimulus(3);
        checkB("B_y3_entry",    4'b0000, 4'b1000, 4'b0111, 3'd3, 1'b1);
        rstB = 1'b1;
        applyStimulus(1);
        rstB = 1'b0;
        checkB("B_rst_in_y",    4'b0000, 4'b0000, 4'b1111, 3'd0, 1'b0);
        applyStimulus(1);
        checkB("B_g0_after",    4'b0001, 4'b0000, 4'b1110, 3'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_n.md
Name: traffic_ctrl_n

Overview:
- Parametrised N-direction traffic-light sequencer; successor to the two-light green/yellow controller.
- Adds:
  - synchronous reset;
  - an all-red clearance interval between directions;
  - per-direction vehicle requests with an actuated (skip / extend) mode;
  - a run-enable that freezes timing;
  - durations sampled at phase entry.
- Drives one g/y/r lamp triple per direction. Sits directly behind the intersection input pads and feeds the lamp drivers.

Parameters:
- NUM_DIR, 2, number of directions (2..8).
- TW, 16, width of the duration inputs and the countdown timer.
- ACTUATED, 1, 1 = request-driven skip/extend; 0 = fixed round-robin.
- IW, 3, width of direction index (must satisfy 2**IW >= NUM_DIR).

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; 0 freezes timer, state and lamps.
- ld_green  in  TW  green duration in ck cycles.
- ld_yellow  in  TW  yellow duration in ck cycles.
- ld_allred  in  TW  all-red clearance duration in ck cycles.
- req  in  NUM_DIR  vehicle request per direction, level-sensitive.
- g  out  NUM_DIR  green lamp per direction, 1 = on.
- y  out  NUM_DIR  yellow lamp per direction, 1 = on.
- r  out  NUM_DIR  red lamp per direction, 1 = on.
- active  out  IW  direction currently owning green/yellow.
- phase_done  out  1  one-cycle pulse on every phase transition.

Behaviour:
- Reset: rst sampled only on rising ck and overrides en.
  - state=ALLRED, active=0, nxt=0, timer=max(ld_allred,1) sampled that edge.
  - g=0, y=0, r=all ones, phase_done=0.
  - Reset mid-phase aborts immediately to this state; no yellow is shown.
- States: GREEN, YELLOW, ALLRED. All outputs are registered.
- Lamp mapping:
  - GREEN: g[active]=1, all other r=1.
  - YELLOW: y[active]=1, all other r=1.
  - ALLRED: r all ones.
  - Exactly one lamp per direction is lit at all times.
- Timer: on entry to a phase, timer loads D = that phase's input, with 0 treated as 1.
  - Each cycle with en=1, timer decrements.
  - The transition fires on the edge where timer==1 and en=1.
  - A phase therefore lasts exactly D enabled cycles.
  - Durations changed mid-phase do not affect the running phase.
- Transitions:
  - ALLRED expiry -> GREEN; active<=nxt.
  - GREEN expiry -> YELLOW; nxt computed here, see Selection.
  - YELLOW expiry -> ALLRED.
- Selection (at GREEN expiry):
  - ACTUATED=0: nxt = (active+1) mod NUM_DIR.
  - ACTUATED=1: nxt = first direction with req=1 scanning active+1, active+2, ... (mod NUM_DIR), excluding active.
    - If no other direction requests, GREEN is extended: timer reloads ld_green, no YELLOW, no phase_done.
  - After reset, the first GREEN always goes to direction 0.
- Index wrap: the modulo wraps at NUM_DIR, not at 2**IW. active never exceeds NUM_DIR-1.
- phase_done: asserted for the single cycle following each state change. Not asserted on extension or on reset.
- en=0:
  - timer, state, active, nxt and lamps hold.
  - phase_done is forced 0 while en=0.
  - A transition due on that edge is deferred until the next en=1 edge.
- Simultaneous events:
  - rst beats everything.
  - req is sampled only on the GREEN-expiry edge; requests that toggle at other times are ignored (no latching).

Test Plan:
- NUM_DIR=2, ACTUATED=0, green=5, yellow=2, allred=1, en=1, release rst:
  - r=11 for 1 cycle;
  - then g[0] for 5 cycles, y[0] for 2, all-red for 1;
  - then g[1] for 5 cycles;
  - phase_done pulses at each change; cycle period is 16.
- NUM_DIR=4, ACTUATED=1, req=0100 held, direction 0 green:
  - after green, yellow and allred, active=2 with g=0100;
  - directions 1 and 3 are skipped.
- ACTUATED=1, req=0000, green=3:
  - direction 0 stays green indefinitely; no phase_done after the first.
  - Then raise req[1]: direction 0 goes yellow within ≤3 cycles.
- Deassert en for 4 cycles mid-green with timer=2:
  - lamps and active frozen; phase_done=0 throughout;
  - green ends exactly 2 enabled cycles after en returns.
- ld_yellow=0:
  - yellow lasts 1 cycle.
  - Change ld_green 5→9 during a green: the current green still lasts 5 cycles and the next green lasts 9.
- Assert rst during YELLOW on direction 3:
  - next cycle r=all ones, g=y=0, active=0;
  - first green after allred is direction 0.
